// File: rtl/tx_serializer.sv
// Frame serializer: latches one FRAME_W-bit frame via valid/ready and shifts it out MSB-first,
// one bit per CLKS_PER_BIT clocks, with a bit clock whose rising edge sits at mid-bit.
module tx_serializer #(
  parameter int FRAME_W      = 11,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               i_Pclk,
  input  logic               i_Rst,
  input  logic [FRAME_W-1:0] i_Frame,
  input  logic               i_Valid,
  output logic               o_Ready,
  output logic               o_Tx,
  output logic               o_Sclk,
  output logic               o_Busy,
  output logic               o_Done
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] shift_reg, shift_nxt;
  logic [CNT_W-1:0]   bit_cnt, cnt_nxt;
  logic [DIV_W-1:0]   div, div_nxt;
  logic               done_q, done_nxt;

  always_ff @(posedge i_Pclk) begin
    if (i_Rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      div       <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= cnt_nxt;
      div       <= div_nxt;
      done_q    <= done_nxt;
    end
  end

  // Bit boundaries happen only on divider wrap, while o_Sclk is low, so the receiver's
  // rising edge always sees stable data.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = bit_cnt;
    div_nxt   = div;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (i_Valid) begin
          shift_nxt = i_Frame;
          cnt_nxt   = CNT_LOAD;
          div_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (div == DIV_LAST) begin
          div_nxt = '0;
          if (bit_cnt != '0) begin
            shift_nxt = {shift_reg[FRAME_W-2:0], 1'b1};
            cnt_nxt   = bit_cnt - 1'b1;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          div_nxt = div + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    o_Ready = (state == IDLE);
    o_Busy  = (state == SHIFT);
    o_Tx    = (state == SHIFT) ? shift_reg[FRAME_W-1] : 1'b1;
    o_Sclk  = (state == SHIFT) && (div >= DIV_HALF);
    o_Done  = done_q;
  end

endmodule

// File: tb/tb_tx_serializer.sv
// Bench for tx_serializer: per-cycle expected line state is queued when a frame is accepted
// and compared against the DUT on every falling edge.
module tb_tx_serializer;

  localparam int FRAME_W = 11;
  localparam int CPB     = 4;

  logic               i_Pclk = 1'b0;
  logic               i_Rst;
  logic [FRAME_W-1:0] i_Frame;
  logic               i_Valid;
  logic               o_Ready, o_Tx, o_Sclk, o_Busy, o_Done;

  tx_serializer #(.FRAME_W(FRAME_W), .CLKS_PER_BIT(CPB)) dut (
    .i_Pclk (i_Pclk),
    .i_Rst  (i_Rst),
    .i_Frame(i_Frame),
    .i_Valid(i_Valid),
    .o_Ready(o_Ready),
    .o_Tx   (o_Tx),
    .o_Sclk (o_Sclk),
    .o_Busy (o_Busy),
    .o_Done (o_Done)
  );

  always #5 i_Pclk = ~i_Pclk;

  typedef struct packed {
    logic tx;
    logic sclk;
    logic busy;
    logic ready;
    logic done;
  } exp_t;

  localparam exp_t IDLE_EXP = '{tx: 1'b1, sclk: 1'b0, busy: 1'b0, ready: 1'b1, done: 1'b0};

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acceptCyc = 0;
  bit   monEn = 0;
  bit   expReadyNow = 1;

  always @(posedge i_Pclk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected line state for cycles T+1 .. T+1+FRAME_W*CPB of a frame accepted at edge T.
  task automatic pushFrame(input logic [FRAME_W-1:0] frame);
    exp_t e;
    for (int k = 0; k < FRAME_W; k++) begin
      for (int j = 0; j < CPB; j++) begin
        e.tx    = frame[FRAME_W-1-k];
        e.sclk  = (j >= CPB / 2);
        e.busy  = 1'b1;
        e.ready = 1'b0;
        e.done  = 1'b0;
        expQ.push_back(e);
      end
    end
    e = IDLE_EXP;
    e.done = 1'b1;
    expQ.push_back(e);
  endtask

  always @(negedge i_Pclk) begin
    if (monEn) begin
      exp_t e;
      e = (expQ.size() > 0) ? expQ.pop_front() : IDLE_EXP;
      checkOutput("tx",    int'(o_Tx),    int'(e.tx));
      checkOutput("sclk",  int'(o_Sclk),  int'(e.sclk));
      checkOutput("busy",  int'(o_Busy),  int'(e.busy));
      checkOutput("ready", int'(o_Ready), int'(e.ready));
      checkOutput("done",  int'(o_Done),  int'(e.done));
      expReadyNow = e.ready;
    end
  end

  // Offers a frame and holds it until the bench model says the block is ready.
  task automatic applyStimulus(input logic [FRAME_W-1:0] frame);
    bit accepted = 0;
    @(negedge i_Pclk); #1;
    i_Frame = frame;
    i_Valid = 1'b1;
    for (int n = 0; n < 200 && !accepted; n++) begin
      if (n > 0) begin
        @(negedge i_Pclk); #1;
      end
      if (expReadyNow) begin
        pushFrame(frame);
        acceptCyc = cyc;
        accepted = 1;
      end
    end
    if (!accepted) checkOutput("accept_timeout", 0, 1);
    @(posedge i_Pclk); #1;
    i_Valid = 1'b0;
  endtask

  task automatic waitCycle(input int target);
    for (int n = 0; n < 500 && cyc < target; n++) @(negedge i_Pclk);
    if (cyc != target) checkOutput("wait_cycle", cyc, target);
  endtask

  task automatic drain(input int extra);
    for (int n = 0; n < 500 && expQ.size() > 0; n++) @(negedge i_Pclk);
    if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 0);
    repeat (extra) @(negedge i_Pclk);
  endtask

  initial begin
    i_Rst   = 1'b1;
    i_Valid = 1'b1;
    i_Frame = 11'h295;
    @(posedge i_Pclk); #1;
    expQ.delete();
    monEn = 1;
    @(posedge i_Pclk); #1;
    i_Rst   = 1'b0;
    i_Valid = 1'b0;
    drain(4);

    $display("[TB] single frame");
    applyStimulus(11'h295);
    drain(3);

    $display("[TB] back-to-back frames");
    applyStimulus(11'h295);
    applyStimulus(11'h3FD);
    drain(3);

    $display("[TB] valid while busy");
    applyStimulus(11'h295);
    waitCycle(acceptCyc + 10);
    #1;
    i_Frame = 11'h000;
    i_Valid = 1'b1;
    @(posedge i_Pclk); #1;
    i_Valid = 1'b0;
    drain(4);

    $display("[TB] reset mid-frame");
    applyStimulus(11'h295);
    waitCycle(acceptCyc + 20);
    #1;
    i_Rst = 1'b1;
    @(posedge i_Pclk);
    expQ.delete();
    #1;
    i_Rst = 1'b0;
    repeat (3) @(negedge i_Pclk);
    applyStimulus(11'h3FD);
    drain(2);

    $display("[TB] frame hold");
    applyStimulus(11'h295);
    for (int n = 0; n < FRAME_W * CPB; n++) begin
      @(negedge i_Pclk); #1;
      i_Frame = FRAME_W'($urandom);
    end
    drain(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tx_serializer.md
Name: tx_serializer

Overview:
- Transmit serializer directly downstream of the transmit parity generator.
- Accepts one 11-bit frame {start, data[7:0], parity, stop} through a valid/ready handshake and latches it.
- Shifts the frame out on a single serial line, one bit per CLKS_PER_BIT clocks, alongside a synchronous bit clock for the receiving side.
- Signals completion with a one-cycle done pulse.

Parameters:
- FRAME_W, 11, frame width in bits; bit FRAME_W-1 is transmitted first.
- CLKS_PER_BIT, 16, system clocks per serial bit; must be even and >= 2.

Ports:
- i_Pclk  input  1  system clock; all logic on the rising edge.
- i_Rst  input  1  synchronous, active-high reset.
- i_Frame  input  FRAME_W  frame to send, {start, data[7:0], parity, stop}; bit 10 is the start bit.
- i_Valid  input  1  i_Frame holds a frame to send.
- o_Ready  output  1  block can accept a frame this cycle.
- o_Tx  output  1  serial data; idles high.
- o_Sclk  output  1  bit clock; rising edge at mid-bit; idles low.
- o_Busy  output  1  a frame is being shifted.
- o_Done  output  1  one-cycle pulse after the last bit period ends.

Behaviour:
- Reset (i_Rst high at a rising edge), all outputs and state:
  - o_Tx=1, o_Sclk=0, o_Busy=0, o_Done=0, o_Ready=1.
  - State IDLE, shift register 0, bit counter 0, divider 0.
- Reset wins over every other event, including mid-frame: the frame in flight is discarded and the line returns high in the next cycle.
- States: IDLE, SHIFT.
- IDLE:
  - o_Ready=1, o_Tx=1, o_Sclk=0.
  - On i_Valid && o_Ready at edge T: latch i_Frame into the shift register, clear the divider, load the bit counter with FRAME_W-1, go to SHIFT.
  - i_Frame is sampled only at that edge; later changes are ignored.
- SHIFT:
  - o_Ready=0, o_Busy=1.
  - o_Tx = current MSB of the shift register.
  - Bit k (k=0 is i_Frame[10]) is driven from cycle T+1+k*CLKS_PER_BIT for exactly CLKS_PER_BIT cycles.
- Divider:
  - Counts 0..CLKS_PER_BIT-1.
  - o_Sclk=0 while the divider < CLKS_PER_BIT/2, and 1 otherwise. The rising edge therefore falls mid-bit, and data changes only while o_Sclk is low.
- Divider wrap (== CLKS_PER_BIT-1):
  - If the bit counter > 0: shift left by one (fill with 1) and decrement the bit counter.
  - If the bit counter == 0: go to IDLE and assert o_Done for the next cycle only.
- Total frame time: FRAME_W*CLKS_PER_BIT cycles. o_Done and o_Ready are both high in cycle T+1+FRAME_W*CLKS_PER_BIT.
- Back-to-back frames: a frame offered with i_Valid in that cycle is accepted there. The line then carries the new start bit one cycle later, with no idle gap beyond that one cycle of o_Tx=1.
- i_Valid while busy: ignored and not consumed. The upstream stage must hold i_Valid and i_Frame until o_Ready.
- Widths:
  - Divider: clog2(CLKS_PER_BIT) bits.
  - Bit counter: clog2(FRAME_W) bits.
  - No overflow is possible within the legal parameter range.

Test Plan (CLKS_PER_BIT=4, FRAME_W=11):
- Reset:
  - Stimulus: hold i_Rst for 2 cycles with i_Valid=1.
  - Required: o_Tx=1, o_Sclk=0, o_Busy=0, o_Done=0, o_Ready=1, and no frame is accepted.
- Single frame:
  - Stimulus: i_Frame=11'h295 (data 0xA5, even parity 0), i_Valid for 1 cycle at T.
  - Required: o_Tx per 4-cycle bit = 0,1,0,1,0,0,1,0,1,0,1 from T+1; o_Sclk pattern 0,0,1,1 per bit.
  - Required: o_Done high only at T+45, with o_Ready=1 there.
- Back-to-back:
  - Stimulus: hold i_Valid with 11'h295 then 11'h3FD.
  - Required: the second frame is accepted at T+45 and its start bit 0 appears at T+46. o_Tx is 1 for exactly one cycle (T+45) between frames.
- Busy ignore:
  - Stimulus: pulse i_Valid with 11'h000 at T+10 during the frame 11'h295.
  - Required: the frame output is unchanged, and the line idles high after T+44.
- Reset mid-frame:
  - Stimulus: assert i_Rst at T+20.
  - Required: at T+21 o_Tx=1, o_Busy=0, o_Ready=1, o_Done never pulses; a new frame is then sent from its start bit.
- Frame hold:
  - Stimulus: change i_Frame every cycle after acceptance of 11'h295.
  - Required: the serial output equals 11'h295 exactly.
